ram_burst_master: RTL and testbench
===================================

# ram_burst_master

Initiator for the single-port 4x8 synchronous RAM port (address, data_in, write_enable, registered data_out). It accepts burst read/write commands from a host over valid/ready, sequences per-beat RAM accesses with address wrap-around, streams write data in and read data out with backpressure, and absorbs the RAM's one-cycle read latency. It sits between host logic and the RAM instance and is the only driver of the RAM port.

## Interface
- ADDR_W, 2, RAM address width; RAM depth is 2**ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  rising-edge clock shared with the RAM
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  beats minus one (0 → 1 beat, 3 → 4 beats)
- wr_valid  in  1  write beat valid
- wr_ready  out  1  high only in WR
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat valid (registered)
- rd_ready  in  1  host accepts read beat
- rd_data  out  DATA_W  read beat data (registered)
- rd_last  out  1  qualifies final beat of a read burst
- busy  out  1  state != IDLE
- ram_address  out  ADDR_W  to RAM address (registered)
- ram_data_in  out  DATA_W  to RAM data_in (registered)
- ram_write_enable  out  1  to RAM write_enable (registered, one-cycle pulse per beat)
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- States: IDLE, WR, RD_A, RD_C, RD_R.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: ptr<=cmd_addr, remaining<=cmd_len, ram_address<=cmd_addr; go to WR if cmd_write, else RD_A.
- WR: wr_ready=1. Each wr_valid cycle is one beat: ram_write_enable<=1, ram_address<=ptr, ram_data_in<=wr_data, ptr<=ptr+1 (mod 2**ADDR_W). If remaining==0 → IDLE, else remaining-1. Cycles without wr_valid: ram_write_enable<=0. Back-to-back beats at one per cycle.
- RD_A: ram_write_enable=0, ram_address=ptr; RAM samples the read. → RD_C unconditionally.
- RD_C: rd_data<=ram_data_out, rd_valid<=1, rd_last<=(remaining==0). → RD_R.
- RD_R: rd_valid, rd_data, rd_last held stable until rd_ready. On rd_ready: rd_valid<=0, rd_last<=0; if last → IDLE, else ptr<=ptr+1, ram_address<=ptr+1, remaining-1, → RD_A.
- Address wrap: ptr increments modulo depth; a burst starting at 3 with cmd_len=1 accesses 3 then 0.
- ram_write_enable is never high outside beat pulses; it is low in all read states.
- Reset (any state, including mid-burst): state IDLE, all outputs 0 (cmd_ready=1 after reset deasserts), pending beats discarded, no partial response issued.

## Timing
- Write beat accepted at edge E → RAM write_enable high in cycle E..E+1 → RAM memory updated at E+1.
- Read: command accepted at E0 → rd_valid high from E2 (two-cycle latency); each subsequent beat rd_valid rises two cycles after the previous rd_ready handshake edge. Peak read throughput one beat per 3 cycles.
- Read-after-write: earliest follow-up command handshake is one cycle after the last write beat; the RAM write has completed before the read is sampled; no hazard, no stall.
- wr_ready and cmd_ready are combinational from state only; no combinational path from any input to any output.

## Configuration
- RAM_BURST_MASTER_STATS_EN defined: adds outputs wr_beat_count and rd_beat_count (16 bits each), incremented per write-beat handshake and per read-beat handshake, saturating at 16'hFFFF, cleared by rst.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset mid-write-burst (after 1 of 4 beats): all outputs 0 next cycle, cmd_ready=1, ram_write_enable never pulses again.
- Write cmd_addr=0, cmd_len=3, data 8'h11,8'h22,8'h33,8'h44 back-to-back → four consecutive ram_write_enable pulses at addresses 0,1,2,3; then read same → rd_data 11,22,33,44, rd_last only on 44.
- Write cmd_addr=3, cmd_len=1, data AA,BB → addresses 3 then 0; read cmd_addr=3 cmd_len=1 → AA, BB.
- Read with rd_ready low 5 cycles on beat 1 → rd_valid/rd_data stable throughout, ram_write_enable stays 0, no beat lost or duplicated.
- Single-beat write 8'h5A at 2 immediately followed by read at 2 → rd_data 8'h5A, rd_valid two cycles after read handshake.
- Write with wr_valid gaps (pattern 1,0,0,1) → ram_write_enable pulses only on valid cycles; with STATS_EN, wr_beat_count=2.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst read/write initiator for a single-port synchronous RAM with registered data_out.
// Optional beat counters: define RAM_BURST_MASTER_STATS_EN.
module ram_burst_master #(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_BURST_MASTER_STATS_EN
   ,
   output logic [15:0]       wr_beat_count,
   output logic [15:0]       rd_beat_count
`endif
);

   typedef enum logic [2:0] {IDLE, WR, RD_A, RD_C, RD_R} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_inc;
   logic [ADDR_W-1:0] remaining;

   assign ptr_inc = ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR : RD_A;
         WR:      if (wr_valid && remaining == '0) state_nxt = IDLE;
         RD_A:    state_nxt = RD_C;
         RD_C:    state_nxt = RD_R;
         RD_R:    if (rd_ready) state_nxt = rd_last ? IDLE : RD_A;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      wr_ready  = (state == WR);
      busy      = (state != IDLE);
   end

   // RAM drive and read response registers; ram_address already holds ptr on entry to RD_A.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr              <= '0;
         remaining        <= '0;
         ram_address      <= '0;
         ram_data_in      <= '0;
         ram_write_enable <= 1'b0;
         rd_valid         <= 1'b0;
         rd_data          <= '0;
         rd_last          <= 1'b0;
      end else begin
         ram_write_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  ptr         <= cmd_addr;
                  remaining   <= cmd_len;
                  ram_address <= cmd_addr;
               end
            end
            WR: begin
               if (wr_valid) begin
                  ram_write_enable <= 1'b1;
                  ram_address      <= ptr;
                  ram_data_in      <= wr_data;
                  ptr              <= ptr_inc;
                  if (remaining != '0) remaining <= remaining - 1'b1;
               end
            end
            RD_C: begin
               rd_data  <= ram_data_out;
               rd_valid <= 1'b1;
               rd_last  <= (remaining == '0);
            end
            RD_R: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  if (!rd_last) begin
                     ptr         <= ptr_inc;
                     ram_address <= ptr_inc;
                     remaining   <= remaining - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RAM_BURST_MASTER_STATS_EN
   logic wr_fire, rd_fire;

   assign wr_fire = (state == WR) && wr_valid;
   assign rd_fire = (state == RD_R) && rd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_beat_count <= '0;
         rd_beat_count <= '0;
      end else begin
         if (wr_fire && wr_beat_count != '1) wr_beat_count <= wr_beat_count + 1'b1;
         if (rd_fire && rd_beat_count != '1) rd_beat_count <= rd_beat_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master driving a behavioural 4x8 synchronous RAM.
module tb_ram_burst_master;
   localparam int unsigned AW = 2;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, cmd_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready, rd_last, busy;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in, ram_data_out;
   logic          ram_write_enable;
`ifdef RAM_BURST_MASTER_STATS_EN
   logic [15:0]   wr_beat_count, rd_beat_count;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned exp_wr = 0;
   int unsigned exp_rd = 0;

   always #5 clk = ~clk;

   ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
`ifdef RAM_BURST_MASTER_STATS_EN
      , .wr_beat_count(wr_beat_count), .rd_beat_count(rd_beat_count)
`endif
   );

   logic [DW-1:0] mem [4];
   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      ram_data_out <= mem[ram_address];
   end

   logic [AW-1:0] wq_a [$];
   logic [DW-1:0] wq_d [$];
   always @(negedge clk) begin
      if (ram_write_enable) begin
         wq_a.push_back(ram_address);
         wq_d.push_back(ram_data_in);
      end
   end

   typedef struct {
      bit             wr;
      logic [1:0]     addr;
      logic [1:0]     len;
      logic [3:0][7:0] d;
      logic [3:0][1:0] ea;
      logic [3:0]     pat;
      int unsigned    stall;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input bit w, input logic [1:0] a, input logic [1:0] l);
      int unsigned t = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      while (!cmd_ready && t < 20) begin tick; t++; end
      chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      tick;
      cmd_valid = 1'b0;
      chk("busy_after_cmd", {31'd0, busy}, 32'd1);
   endtask

   task automatic run_write(input vec_t v);
      int unsigned beat = 0;
      wq_a.delete(); wq_d.delete();
      for (int unsigned c = 0; c < 4 && beat <= v.len; c++) begin
         chk("wr_ready", {31'd0, wr_ready}, 32'd1);
         wr_valid = v.pat[3-c];
         wr_data  = v.pat[3-c] ? v.d[beat] : 8'h00;
         tick;
         if (v.pat[3-c]) begin beat++; exp_wr++; end
      end
      wr_valid = 1'b0;
      chk("wr_beats_sent", beat, v.len + 1);
      @(negedge clk);
      #1;
      chk("wr_pulse_count", wq_a.size(), v.len + 1);
      for (int unsigned i = 0; i < wq_a.size() && i < 4; i++) begin
         chk("wr_addr", {30'd0, wq_a[i]}, {30'd0, v.ea[i]});
         chk("wr_data", {24'd0, wq_d[i]}, {24'd0, v.d[i]});
      end
      chk("wr_done_idle", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic run_read(input vec_t v);
      wq_a.delete(); wq_d.delete();
      for (int unsigned b = 0; b <= v.len; b++) begin
         int unsigned lat = 0;
         while (!rd_valid && lat < 10) begin tick; lat++; end
         chk("rd_latency", lat, 2);
         chk("rd_data", {24'd0, rd_data}, {24'd0, v.d[b]});
         chk("rd_last", {31'd0, rd_last}, {31'd0, (b == v.len)});
         if (b == 1) begin
            for (int unsigned s = 0; s < v.stall; s++) begin
               tick;
               chk("stall_valid", {31'd0, rd_valid}, 32'd1);
               chk("stall_data", {24'd0, rd_data}, {24'd0, v.d[b]});
               chk("stall_we", {31'd0, ram_write_enable}, 32'd0);
            end
         end
         rd_ready = 1'b1;
         tick;
         rd_ready = 1'b0;
         exp_rd++;
         chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
      end
      chk("rd_done_idle", {31'd0, cmd_ready}, 32'd1);
      chk("rd_no_we_pulse", wq_a.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 2'd0, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111, 0};
      tbl[1] = '{1'b0, 2'd0, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}, 8'd0, 4'b0000, 0};
      tbl[2] = '{1'b1, 2'd3, 2'd1, {16'h0, 8'hBB, 8'hAA}, {4'd0, 2'd0, 2'd3}, 4'b1111, 0};
      tbl[3] = '{1'b0, 2'd3, 2'd1, {16'h0, 8'hBB, 8'hAA}, 8'd0, 4'b0000, 0};
      tbl[4] = '{1'b1, 2'd2, 2'd0, {24'h0, 8'h5A}, {6'd0, 2'd2}, 4'b1111, 0};
      tbl[5] = '{1'b0, 2'd2, 2'd0, {24'h0, 8'h5A}, 8'd0, 4'b0000, 0};
      tbl[6] = '{1'b0, 2'd0, 2'd3, {8'hAA, 8'h5A, 8'h22, 8'hBB}, 8'd0, 4'b0000, 5};
      tbl[7] = '{1'b1, 2'd1, 2'd1, {16'h0, 8'hD4, 8'hC3}, {4'd0, 2'd2, 2'd1}, 4'b1001, 0};
      tbl[8] = '{1'b0, 2'd1, 2'd1, {16'h0, 8'hD4, 8'hC3}, 8'd0, 4'b0000, 0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      tick; tick;
      chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_we", {31'd0, ram_write_enable}, 32'd0);
      chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      rst = 1'b0;
      tick;

      // Reset in the middle of a four-beat write burst
      do_cmd(1'b1, 2'd0, 2'd3);
      wr_valid = 1'b1; wr_data = 8'h77;
      tick;
      chk("midburst_beat_pulse", {31'd0, ram_write_enable}, 32'd1);
      rst = 1'b1;
      tick;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, ram_write_enable}, 32'd0);
      chk("rst_address", {30'd0, ram_address}, 32'd0);
      chk("rst_data_in", {24'd0, ram_data_in}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
      chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
      rst = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      wq_a.delete(); wq_d.delete();
      repeat (5) tick;
      chk("post_rst_no_pulse", wq_a.size(), 0);
      chk("post_rst_idle", {31'd0, cmd_ready}, 32'd1);
      wr_valid = 1'b0;

      for (int unsigned i = 0; i < 9; i++) begin
         do_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len);
         if (tbl[i].wr) run_write(tbl[i]);
         else           run_read(tbl[i]);
      end

`ifdef RAM_BURST_MASTER_STATS_EN
      chk("wr_beat_count", {16'd0, wr_beat_count}, exp_wr);
      chk("rd_beat_count", {16'd0, rd_beat_count}, exp_rd);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
